// File: rtl/mem_pkg.sv
// Shared types for the mainmem port arbiter.
// Size codes, memory direction and FSM states.
package mem_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ERR  = 2'd3
  } mem_state_t;

  // Size 3 behaves as word; bytes are never misaligned.
  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    unique case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_align.sv
// Lane steering: load extract/extend and sub-word store merge.
// word/off/size/uns/wdata in; load_data, store_word out.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [31:0] bw;
  logic [31:0] hw;

  always_comb begin
    bsh = {off, 3'b000};
    hsh = {off[1], 4'b0000};
    bw  = word >> bsh;
    hw  = word >> hsh;
    load_data  = word;
    store_word = wdata;
    unique case (size)
      SIZE_BYTE: begin
        load_data = uns ? {24'b0, bw[7:0]}
                        : {{24{bw[7]}}, bw[7:0]};
        store_word = (word & ~(32'h0000_00FF << bsh))
                   | ({24'b0, wdata[7:0]} << bsh);
      end
      SIZE_HALF: begin
        load_data = uns ? {16'b0, hw[15:0]}
                        : {{16{hw[15]}}, hw[15:0]};
        store_word = (word & ~(32'h0000_FFFF << hsh))
                   | ({16'b0, wdata[15:0]} << hsh);
      end
      default: begin
        load_data  = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares mainmem between fetch and load/store; RMW for sub-word stores.
// Ports: clock/reset_n, if_* fetch port, d_* data port, mem_* to mainmem.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_misaligned,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_write
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = STARVE_LIMIT[CW-1:0];

  mem_state_t    state, state_nxt;
  logic [CW-1:0] loss_cnt, loss_nxt;
  logic          any_req, f_win;
  logic          r_fetch, r_we, r_uns;
  logic [1:0]    r_size, r_off;
  logic [31:0]   r_wdata;
  logic [31:0]   ld_data, st_word;
  logic          unused_bits;

  assign unused_bits = ^if_addr[1:0];

  mem_lane_align u_align (
    .word       (mem_data_out),
    .off        (r_off),
    .size       (r_size),
    .uns        (r_uns),
    .wdata      (r_wdata),
    .load_data  (ld_data),
    .store_word (st_word)
  );

  always_comb begin
    any_req   = if_req | d_req;
    f_win     = if_req & (~d_req | (loss_cnt == LIM));
    state_nxt = state;
    loss_nxt  = loss_cnt;
    unique case (state)
      IDLE: if (any_req) begin
        unique case (1'b1)
          f_win:
            state_nxt = RD;
          is_misaligned(d_size, d_addr[1:0]):
            state_nxt = ERR;
          d_we & d_size[1]:
            state_nxt = WR;
          default:
            state_nxt = RD;
        endcase
      end
      RD:      state_nxt = (!r_fetch && r_we) ? WR : IDLE;
      default: state_nxt = IDLE;
    endcase
    // Loss counter saturates at the limit; any fetch win clears it.
    if (!if_req) begin
      loss_nxt = '0;
    end else if (state == IDLE) begin
      if (f_win)
        loss_nxt = '0;
      else if (loss_cnt != LIM)
        loss_nxt = loss_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      loss_cnt       <= '0;
      if_gnt         <= 1'b0;
      if_rvalid      <= 1'b0;
      if_rdata       <= '0;
      d_gnt          <= 1'b0;
      d_rvalid       <= 1'b0;
      d_rdata        <= '0;
      d_misaligned   <= 1'b0;
      mem_address    <= '0;
      mem_data_in    <= '0;
      mem_read_write <= MEM_READ;
      r_fetch        <= 1'b0;
      r_we           <= 1'b0;
      r_uns          <= 1'b0;
      r_size         <= SIZE_WORD;
      r_off          <= 2'b00;
      r_wdata        <= '0;
    end else begin
      state        <= state_nxt;
      loss_cnt     <= loss_nxt;
      if_gnt       <= 1'b0;
      if_rvalid    <= 1'b0;
      d_gnt        <= 1'b0;
      d_rvalid     <= 1'b0;
      d_misaligned <= 1'b0;
      unique case (state)
        IDLE: begin
          mem_read_write <= MEM_READ;
          mem_data_in    <= '0;
          if (any_req) begin
            if (f_win) begin
              if_gnt      <= 1'b1;
              r_fetch     <= 1'b1;
              r_we        <= 1'b0;
              r_size      <= SIZE_WORD;
              r_uns       <= 1'b0;
              r_off       <= 2'b00;
              mem_address <= {if_addr[31:2], 2'b00};
            end else begin
              d_gnt   <= 1'b1;
              r_fetch <= 1'b0;
              r_we    <= d_we;
              r_size  <= d_size;
              r_uns   <= d_unsigned;
              r_off   <= d_addr[1:0];
              r_wdata <= d_wdata;
              if (state_nxt != ERR)
                mem_address <= {d_addr[31:2], 2'b00};
              if (state_nxt == WR) begin
                mem_read_write <= MEM_WRITE;
                mem_data_in    <= d_wdata;
              end
            end
          end
        end
        RD: begin
          if (r_fetch) begin
            if_rvalid <= 1'b1;
            if_rdata  <= mem_data_out;
          end else if (!r_we) begin
            d_rvalid <= 1'b1;
            d_rdata  <= ld_data;
          end else begin
            mem_read_write <= MEM_WRITE;
            mem_data_in    <= st_word;
          end
        end
        WR: begin
          d_rvalid       <= 1'b1;
          d_rdata        <= '0;
          mem_read_write <= MEM_READ;
          mem_data_in    <= '0;
        end
        default: begin
          d_rvalid     <= 1'b1;
          d_misaligned <= 1'b1;
          d_rdata      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a word-wide mainmem model.
// Checks timing, lane handling, misalignment, starvation and reset.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'd0;
  logic        d_unsigned = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid, d_misaligned;
  logic [31:0] d_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write;

  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  int n_asrt = 0;
  int n_fail = 0;
  int ng;
  logic [9:0] gseq;

  always #5 clock = ~clock;

  assign mem_data_out = mem[mem_address[7:2]];

  always @(posedge clock) begin
    if (pre_we)
      mem[pre_idx] <= pre_val;
    else if (mem_read_write)
      mem[mem_address[7:2]] <= mem_data_in;
  end

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_gnt         (if_gnt),
    .if_rvalid      (if_rvalid),
    .if_rdata       (if_rdata),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_size         (d_size),
    .d_unsigned     (d_unsigned),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_gnt          (d_gnt),
    .d_rvalid       (d_rvalid),
    .d_rdata        (d_rdata),
    .d_misaligned   (d_misaligned),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_read_write (mem_read_write)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_if_gnt"}, {31'b0, if_gnt}, 32'd0);
    chk({p, "_if_rvalid"}, {31'b0, if_rvalid}, 32'd0);
    chk({p, "_if_rdata"}, if_rdata, 32'd0);
    chk({p, "_d_gnt"}, {31'b0, d_gnt}, 32'd0);
    chk({p, "_d_rvalid"}, {31'b0, d_rvalid}, 32'd0);
    chk({p, "_d_mis"}, {31'b0, d_misaligned}, 32'd0);
    chk({p, "_d_rdata"}, d_rdata, 32'd0);
    chk({p, "_mem_addr"}, mem_address, 32'd0);
    chk({p, "_mem_din"}, mem_data_in, 32'd0);
    chk({p, "_mem_rw"}, {31'b0, mem_read_write}, 32'd0);
  endtask

  task automatic poke(input logic [5:0] i, input logic [31:0] v);
    pre_we  = 1'b1;
    pre_idx = i;
    pre_val = v;
    @(negedge clock);
    pre_we  = 1'b0;
  endtask

  // Called at a negedge; returns in the cycle after the sampling edge.
  task automatic dreq(input logic we, input logic [1:0] sz,
                      input logic un, input logic [31:0] a,
                      input logic [31:0] wd);
    d_req      = 1'b1;
    d_we       = we;
    d_size     = sz;
    d_unsigned = un;
    d_addr     = a;
    d_wdata    = wd;
    @(negedge clock);
    d_req      = 1'b0;
  endtask

  task automatic load(input string tag, input logic [1:0] sz,
                      input logic un, input logic [31:0] a,
                      input logic [31:0] exp);
    dreq(1'b0, sz, un, a, 32'h0);
    chk({tag, "_gnt"}, {31'b0, d_gnt}, 32'd1);
    chk({tag, "_addr"}, mem_address, {a[31:2], 2'b00});
    @(negedge clock);
    chk({tag, "_rvalid"}, {31'b0, d_rvalid}, 32'd1);
    chk({tag, "_rdata"}, d_rdata, exp);
    chk({tag, "_mis"}, {31'b0, d_misaligned}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) poke(i[5:0], 32'h0);
    poke(6'd0, 32'hFF008001);
    poke(6'd1, 32'h11223344);
    poke(6'd3, 32'h55667788);
    chk_reset("rst");
    reset_n = 1'b1;
    @(negedge clock);

    load("lhu", SIZE_HALF, 1'b1, 32'h01000002, 32'h0000FF00);
    load("lh",  SIZE_HALF, 1'b0, 32'h01000002, 32'hFFFFFF00);
    load("lb0", SIZE_BYTE, 1'b0, 32'h01000000, 32'h00000001);
    load("lb1", SIZE_BYTE, 1'b0, 32'h01000001, 32'hFFFFFF80);
    load("lbu", SIZE_BYTE, 1'b1, 32'h01000001, 32'h00000080);

    dreq(1'b1, SIZE_BYTE, 1'b0, 32'h01000005, 32'h000000AB);
    chk("sb_gnt", {31'b0, d_gnt}, 32'd1);
    chk("sb_rd", {31'b0, mem_read_write}, 32'd0);
    @(negedge clock);
    chk("sb_wr", {31'b0, mem_read_write}, 32'd1);
    chk("sb_din", mem_data_in, 32'h1122AB44);
    chk("sb_early", {31'b0, d_rvalid}, 32'd0);
    @(negedge clock);
    chk("sb_ack", {31'b0, d_rvalid}, 32'd1);
    chk("sb_rdata", d_rdata, 32'd0);
    chk("sb_mem", mem[1], 32'h1122AB44);

    dreq(1'b1, SIZE_HALF, 1'b0, 32'h01000006, 32'h1234BEEF);
    @(negedge clock);
    @(negedge clock);
    chk("sh_ack", {31'b0, d_rvalid}, 32'd1);
    chk("sh_mem", mem[1], 32'hBEEFAB44);

    dreq(1'b1, SIZE_WORD, 1'b0, 32'h01000008, 32'hCAFEF00D);
    chk("sw_wr", {31'b0, mem_read_write}, 32'd1);
    chk("sw_din", mem_data_in, 32'hCAFEF00D);
    @(negedge clock);
    chk("sw_ack", {31'b0, d_rvalid}, 32'd1);
    chk("sw_mem", mem[2], 32'hCAFEF00D);

    dreq(1'b0, SIZE_HALF, 1'b1, 32'h01000003, 32'h0);
    chk("mis_gnt", {31'b0, d_gnt}, 32'd1);
    chk("mis_rw1", {31'b0, mem_read_write}, 32'd0);
    @(negedge clock);
    chk("mis_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("mis_flag", {31'b0, d_misaligned}, 32'd1);
    chk("mis_rdata", d_rdata, 32'd0);
    chk("mis_rw2", {31'b0, mem_read_write}, 32'd0);
    @(negedge clock);
    chk("mis_clear", {31'b0, d_misaligned}, 32'd0);

    load("lw", SIZE_WORD, 1'b0, 32'h01000004, 32'hBEEFAB44);

    if_req  = 1'b1;
    if_addr = 32'h01000000;
    @(negedge clock);
    chk("f1_gnt", {31'b0, if_gnt}, 32'd1);
    if_addr = 32'h01000004;
    @(negedge clock);
    chk("f1_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("f1_rdata", if_rdata, 32'hFF008001);
    @(negedge clock);
    chk("f2_gnt", {31'b0, if_gnt}, 32'd1);
    if_req = 1'b0;
    @(negedge clock);
    chk("f2_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("f2_rdata", if_rdata, 32'hBEEFAB44);

    d_we       = 1'b0;
    d_size     = SIZE_WORD;
    d_unsigned = 1'b0;
    d_addr     = 32'h01000000;
    if_addr    = 32'h01000000;
    if_req     = 1'b1;
    d_req      = 1'b1;
    ng         = 0;
    gseq       = '0;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      @(negedge clock);
      if (d_gnt) ng++;
      if (if_gnt) begin
        if (ng < 10) gseq[ng] = 1'b1;
        ng++;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    chk("starve_count", ng, 32'd10);
    chk("starve_order", {22'b0, gseq}, 32'h210);
    repeat (3) @(negedge clock);

    dreq(1'b1, SIZE_BYTE, 1'b0, 32'h0100000C, 32'h00000099);
    chk("rw_gnt", {31'b0, d_gnt}, 32'd1);
    @(negedge clock);
    chk("rw_inwr", {31'b0, mem_read_write}, 32'd1);
    #1 reset_n = 1'b0;
    #1 chk("rw_rst_rw", {31'b0, mem_read_write}, 32'd0);
    @(negedge clock);
    chk("rw_mem", mem[3], 32'h55667788);
    chk_reset("rw");
    reset_n = 1'b1;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
